// File: rtl/ysyx_220066_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per BUSY cycle; divide-by-zero and signed overflow finish in one cycle.
module ysyx_220066_div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CW   = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            word_q;
  logic [XLEN-1:0] quotient_q;
  logic [XLEN-1:0] remainder_q;

  // Operand preparation at accept
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_sext, min_val;
  logic            a_neg, b_neg, div_zero, overflow;

  always_comb begin
    a_sext = {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]};
    if (div_word) begin
      a_ext = div_signed ? a_sext : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_ext = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                         : {{HALF{1'b0}}, divisor[HALF-1:0]};
      min_val = {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}};
    end else begin
      a_ext   = dividend;
      b_ext   = divisor;
      min_val = {1'b1, {(XLEN - 1){1'b0}}};
    end
    a_neg    = div_signed & a_ext[XLEN-1];
    b_neg    = div_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    overflow = div_signed & (b_ext == '1) & (a_ext == min_val);
  end

  // One restoring step plus the sign/width fixup applied on the final step
  logic [XLEN:0]   shifted, diff, rem_nxt;
  logic [XLEN-1:0] quo_nxt, q_fix, r_fix, q_out, r_out;
  logic            qbit;

  always_comb begin
    shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    qbit    = ~diff[XLEN];
    rem_nxt = qbit ? diff : shifted;
    quo_nxt = {quo_q[XLEN-2:0], qbit};
    q_fix   = neg_q_q ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fix   = neg_r_q ? (~rem_nxt[XLEN-1:0] + 1'b1) : rem_nxt[XLEN-1:0];
    q_out   = word_q ? {{HALF{q_fix[HALF-1]}}, q_fix[HALF-1:0]} : q_fix;
    r_out   = word_q ? {{HALF{r_fix[HALF-1]}}, r_fix[HALF-1:0]} : r_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      word_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q <= div_word;
            if (div_zero) begin
              quotient_q  <= '1;
              remainder_q <= div_word ? a_sext : dividend;
              state_q     <= StDone;
            end else if (overflow) begin
              quotient_q  <= a_ext;
              remainder_q <= '0;
              state_q     <= StDone;
            end else begin
              rem_q   <= '0;
              // W forms run HALF steps, so park the dividend in the upper half
              quo_q   <= div_word ? (a_mag << HALF) : a_mag;
              dsr_q   <= b_mag;
              cnt_q   <= div_word ? CW'(HALF - 1) : CW'(XLEN - 1);
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= q_out;
            remainder_q <= r_out;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_220066_div_unit.sv
// Directed self-checking bench for ysyx_220066_div_unit: latency, results, back-pressure,
// flush and mid-operation reset.
module tb_ysyx_220066_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_signed;
  logic        div_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_220066_div_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .div_word   (div_word),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  // Present one op at a negedge, accept on the next posedge (cycle T), then count cycles
  // until out_valid, sampling 1ns after each posedge.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, input int exp_lat,
                        input logic [63:0] exp_q, input logic [63:0] exp_r);
    int lat;
    @(negedge clk);
    dividend   = a;
    divisor    = b;
    div_signed = s;
    div_word   = w;
    in_valid   = 1'b1;
    check_val({tag, ".ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, ".q"}, quotient, exp_q);
    check_val({tag, ".r"}, remainder, exp_r);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] hold_q, hold_r;
    rst        = 1'b1;
    in_valid   = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_signed = 1'b0;
    div_word   = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst.in_ready", 64'(in_ready), 64'd0);
    check_val("rst.out_valid", 64'(out_valid), 64'd0);
    check_val("rst.q", quotient, 64'd0);
    check_val("rst.r", remainder, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("post_rst.in_ready", 64'(in_ready), 64'd1);

    run_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 65, 64'd14, 64'd2);
    run_op("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 65,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
    run_op("divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1'b0, 1'b0, 65,
           64'hFFFF_FFFF, 64'hFFFF_FFFF);
    run_op("divu_by0", 64'h1234, 64'd0, 1'b0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,
           64'h8000_0000_0000_0000, 64'd0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1,
           64'hFFFF_FFFF_8000_0000, 64'd0);
    run_op("remuw_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1, 33, 64'h7FFF_FFFF, 64'd1);
    run_op("divw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 33,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divuw_sext", 64'h1234_5678_8000_0000, 64'd1, 1'b0, 1'b1, 33,
           64'hFFFF_FFFF_8000_0000, 64'd0);
    run_op("divuw_by0", 64'h0000_0000_FFFF_FFF0, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, 1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0);

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_op("bp", 64'd100, 64'd7, 1'b0, 1'b0, 65, 64'd14, 64'd2);
    hold_q = quotient;
    hold_r = remainder;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp.q_hold", quotient, 64'd14);
      check_val("bp.r_hold", remainder, 64'd2);
      check_val("bp.valid", 64'(out_valid), 64'd1);
      check_val("bp.in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp.release_ready", 64'(in_ready), 64'd1);
    check_val("bp.release_valid", 64'(out_valid), 64'd0);

    // Flush during cycle T+10, then a new op accepted at T+11
    @(negedge clk);
    dividend   = 64'd1000;
    divisor    = 64'd3;
    div_signed = 1'b0;
    div_word   = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("flush.out_valid", 64'(out_valid), 64'd0);
    check_val("flush.in_ready", 64'(in_ready), 64'd1);
    // run_op's negedge falls in this same cycle (T+11), so the accept lands here
    run_op("post_flush_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 65, 64'd3, 64'd0);

    // Reset mid-operation zeroes the outputs
    @(negedge clk);
    dividend = 64'd50;
    divisor  = 64'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst.q", quotient, 64'd0);
    check_val("midrst.r", remainder, 64'd0);
    check_val("midrst.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_50_5", 64'd50, 64'd5, 1'b0, 1'b0, 65, 64'd10, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
